// File: rtl/lzd_norm_pipe.sv
// ---------------------------------------------------------------------------
// lzd_norm_pipe
//
// Two-stage pipelined leading-digit detector and normaliser for the
// floating-point datapath. Each transaction counts the leading zeros
// (mode_i=0) or leading ones (mode_i=1) of an IN_W-bit operand. It then
// left-shifts the operand by that count so that the first terminating digit
// lands in the MSB. A user tag rides alongside every operand.
//
// The pipeline uses a valid/ready handshake on both sides with full
// backpressure. rdy_o is combinational from rdy_i, so a full pipeline can
// accept a new operand in the same cycle it hands its oldest result
// downstream.
//
// Ports:
//   clk     in   1      clock, all state updates on the rising edge
//   rst_n   in   1      asynchronous active-low reset
//   vld_i   in   1      input operand valid
//   rdy_o   out  1      block can accept an input this cycle
//   in      in   IN_W   operand
//   mode_i  in   1      0 = count leading zeros, 1 = count leading ones
//   tag_i   in   TAG_W  sideband tag
//   vld_o   out  1      result valid
//   rdy_i   in   1      downstream accepts the result this cycle
//   cnt_o   out  CNT_W  leading-digit count (IN_W when no terminator found)
//   norm_o  out  IN_W   operand << cnt_o, truncated, zero-filled from LSB
//   sat_o   out  1      no terminating digit found in the operand
//   tag_o   out  TAG_W  tag of the result
// ---------------------------------------------------------------------------
module lzd_norm_pipe #(
    parameter int IN_W  = 15,
    parameter int CNT_W = $clog2(IN_W + 1),
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld_i,
    output logic             rdy_o,
    input  logic [IN_W-1:0]  in,
    input  logic             mode_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             vld_o,
    input  logic             rdy_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [IN_W-1:0]  norm_o,
    output logic             sat_o,
    output logic [TAG_W-1:0] tag_o
);

    // Stage-1 (count) registers
    logic             s1_vld;
    logic [IN_W-1:0]  s1_op;
    logic [CNT_W-1:0] s1_cnt;
    logic             s1_sat;
    logic [TAG_W-1:0] s1_tag;

    // Handshake and datapath nets
    logic             s1_adv;
    logic             s2_adv;
    logic [IN_W-1:0]  digit_vec;
    logic [CNT_W-1:0] lead_cnt;
    logic             lead_found;
    logic [IN_W-1:0]  norm_next;

    // Stage 2 advances when it is empty or when downstream takes its
    // result. Stage 1 advances when it is empty or when stage 2 advances.
    // Chaining the two like this lets a full pipeline keep streaming at
    // one result per cycle without a bubble. The price is a combinational
    // path from rdy_i to rdy_o, which is intentional.
    always_comb begin
        s2_adv = ~vld_o | rdy_i;
        s1_adv = ~s1_vld | s2_adv;
        rdy_o  = s1_adv;
    end

    // Counting leading ones is the same job as counting leading zeros of
    // the inverted operand, so both modes share one priority detector.
    // The detector finds the most significant set bit of digit_vec.
    // When no bit is set, the count saturates at IN_W instead of wrapping,
    // which is why CNT_W has to be able to represent IN_W itself.
    always_comb begin
        digit_vec  = mode_i ? ~in : in;
        lead_cnt   = CNT_W'(IN_W);
        lead_found = 1'b0;
        for (int i = IN_W - 1; i >= 0; i--) begin
            if (!lead_found && digit_vec[i]) begin
                lead_cnt   = CNT_W'(IN_W - 1 - i);
                lead_found = 1'b1;
            end
        end
    end

    // Stage-1 valid flag. It follows the upstream valid whenever the stage
    // advances, so an un-accepted slot simply becomes a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
        end else if (s1_adv) begin
            s1_vld <= vld_i;
        end
    end

    // Stage-1 data. It captures the operand, tag, count and saturation flag
    // only on a real input fire. Mode is not stored separately because it
    // is already folded into the count and sat values. While the stage is
    // stalled, the data holds so that nothing upstream can disturb a
    // waiting operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_op  <= '0;
            s1_cnt <= '0;
            s1_sat <= 1'b0;
            s1_tag <= '0;
        end else if (s1_adv && vld_i) begin
            s1_op  <= in;
            s1_cnt <= lead_cnt;
            s1_sat <= ~lead_found;
            s1_tag <= tag_i;
        end
    end

    // Normalising shift. A saturated count equals IN_W, and the result for
    // it must be all zeros. Forcing zero explicitly keeps that outcome
    // independent of how the shifter treats an amount equal to the width.
    always_comb begin
        norm_next = s1_op << s1_cnt;
        if (s1_sat) begin
            norm_next = '0;
        end
    end

    // Stage-2 valid flag, which drives vld_o directly. The asynchronous
    // reset makes vld_o drop immediately when rst_n asserts, so in-flight
    // results are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_o <= 1'b0;
        end else if (s2_adv) begin
            vld_o <= s1_vld;
        end
    end

    // Stage-2 data, which drives the result outputs directly. It loads only
    // when stage 2 advances and stage 1 holds a real operand. Otherwise it
    // holds, so that every output stays stable while downstream stalls a
    // valid result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_o  <= '0;
            norm_o <= '0;
            sat_o  <= 1'b0;
            tag_o  <= '0;
        end else if (s2_adv && s1_vld) begin
            cnt_o  <= s1_cnt;
            norm_o <= norm_next;
            sat_o  <= s1_sat;
            tag_o  <= s1_tag;
        end
    end

endmodule

// File: tb/tb_lzd_norm_pipe.sv
// ---------------------------------------------------------------------------
// tb_lzd_norm_pipe
//
// Self-checking bench for lzd_norm_pipe with IN_W=15 and TAG_W=4.
// A background monitor does two jobs. It pushes every accepted operand
// through a plain behavioural model into an expectation queue. It then
// checks each delivered result, plus output stability under stall, against
// that queue. The main thread drives directed vectors with literal
// expectations, a backpressure scenario, a random stream and a mid-flight
// reset.
// ---------------------------------------------------------------------------
module tb_lzd_norm_pipe;

    localparam int IN_W  = 15;
    localparam int TAG_W = 4;
    localparam int CNT_W = $clog2(IN_W + 1);

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b1;
    logic             vld_i  = 1'b0;
    logic             mode_i = 1'b0;
    logic             rdy_i  = 1'b1;
    logic [IN_W-1:0]  in_op  = '0;
    logic [TAG_W-1:0] tag_i  = '0;
    logic             rdy_o;
    logic             vld_o;
    logic [CNT_W-1:0] cnt_o;
    logic [IN_W-1:0]  norm_o;
    logic             sat_o;
    logic [TAG_W-1:0] tag_o;

    typedef struct {
        int              cnt;
        longint unsigned norm;
        bit              sat;
        int              tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   out_count = 0;
    int   acc_count = 0;

    lzd_norm_pipe #(
        .IN_W  (IN_W),
        .CNT_W (CNT_W),
        .TAG_W (TAG_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_i  (vld_i),
        .rdy_o  (rdy_o),
        .in     (in_op),
        .mode_i (mode_i),
        .tag_i  (tag_i),
        .vld_o  (vld_o),
        .rdy_i  (rdy_i),
        .cnt_o  (cnt_o),
        .norm_o (norm_o),
        .sat_o  (sat_o),
        .tag_o  (tag_o)
    );

    always #5 clk = ~clk;

    // Reference model: walk from the MSB while bits equal the counted digit,
    // then shift with wide arithmetic and mask back down to IN_W bits.
    function automatic exp_t model(input logic [IN_W-1:0] op, input logic m,
                                   input logic [TAG_W-1:0] t);
        exp_t            e;
        int              n = 0;
        longint unsigned v;
        while (n < IN_W && op[IN_W-1-n] == m) n++;
        v      = longint'(op);
        v      = (v << n) & ((64'd1 << IN_W) - 64'd1);
        e.cnt  = n;
        e.norm = v;
        e.sat  = (n == IN_W);
        e.tag  = int'(t);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: checks results on output fire and stability under stall,
    // then records newly accepted inputs into the model queue.
    initial begin : monitor
        exp_t             e;
        bit               hold_prev = 1'b0;
        logic [CNT_W-1:0] h_cnt;
        logic [IN_W-1:0]  h_norm;
        logic             h_sat;
        logic [TAG_W-1:0] h_tag;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    checkOutput("hold_vld", vld_o, 1);
                    checkOutput("hold_cnt", cnt_o, h_cnt);
                    checkOutput("hold_norm", norm_o, h_norm);
                    checkOutput("hold_sat", sat_o, h_sat);
                    checkOutput("hold_tag", tag_o, h_tag);
                end
                if (vld_o && rdy_i) begin
                    out_count++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_result actual=vld_o=1 required=no result");
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("model_cnt", cnt_o, e.cnt);
                        checkOutput("model_norm", norm_o, e.norm);
                        checkOutput("model_sat", sat_o, e.sat);
                        checkOutput("model_tag", tag_o, e.tag);
                    end
                end
                hold_prev = vld_o && !rdy_i;
                h_cnt     = cnt_o;
                h_norm    = norm_o;
                h_sat     = sat_o;
                h_tag     = tag_o;
                if (vld_i && rdy_o) begin
                    exp_q.push_back(model(in_op, mode_i, tag_i));
                    acc_count++;
                end
            end
        end
    end

    // Present one operand (called at posedge+1) and hold it until accepted.
    // Returns just after the accepting edge with vld_i dropped.
    task automatic applyStimulus(input logic [IN_W-1:0] op, input logic m,
                                 input logic [TAG_W-1:0] t);
        bit ok = 1'b0;
        int n  = 0;
        vld_i  = 1'b1;
        in_op  = op;
        mode_i = m;
        tag_i  = t;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = rdy_o;
            @(posedge clk);
            #1;
            n++;
        end
        vld_i = 1'b0;
        if (!ok) checkOutput("accept_timeout", 0, 1);
    endtask

    // Directed vector with literal expectations and exact two-cycle latency.
    task automatic runDirected(input logic [IN_W-1:0] op, input logic m,
                               input logic [TAG_W-1:0] t, input int ecnt,
                               input logic [IN_W-1:0] enorm, input logic esat);
        applyStimulus(op, m, t);
        @(negedge clk);
        checkOutput("lat_early_vld", vld_o, 0);
        @(negedge clk);
        checkOutput("lat_vld", vld_o, 1);
        checkOutput("dir_cnt", cnt_o, ecnt);
        checkOutput("dir_norm", norm_o, enorm);
        checkOutput("dir_sat", sat_o, esat);
        checkOutput("dir_tag", tag_o, t);
        @(posedge clk);
        #1;
    endtask

    // Global watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        exp_t             pm;
        logic [IN_W-1:0]  bp_ops[4];
        int               idx;
        bit               f;
        int               base;
        int               cycles;
        int               target;
        logic [CNT_W-1:0] s_cnt;
        logic [IN_W-1:0]  s_norm;
        logic [TAG_W-1:0] s_tag;
        logic [IN_W-1:0]  rop;

        // Pin the model itself against hand-computed values
        pm = model(15'h0400, 1'b0, 4'd3);
        checkOutput("pin_cnt_0400", pm.cnt, 4);
        checkOutput("pin_norm_0400", pm.norm, 15'h4000);
        pm = model(15'h7F00, 1'b1, 4'd0);
        checkOutput("pin_cnt_7f00", pm.cnt, 7);
        checkOutput("pin_norm_7f00", pm.norm, 0);
        pm = model(15'h0000, 1'b0, 4'd0);
        checkOutput("pin_sat_zero", pm.sat, 1);
        checkOutput("pin_cnt_zero", pm.cnt, 15);

        // Reset state
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_vld_o", vld_o, 0);
        checkOutput("rst_cnt_o", cnt_o, 0);
        checkOutput("rst_norm_o", norm_o, 0);
        checkOutput("rst_sat_o", sat_o, 0);
        checkOutput("rst_tag_o", tag_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_rdy_o", rdy_o, 1);
        @(posedge clk);
        #1;

        // Directed vectors
        $display("[TB] directed vectors");
        runDirected(15'h0400, 1'b0, 4'd3, 4,  15'h4000, 1'b0);
        runDirected(15'h0000, 1'b0, 4'd5, 15, 15'h0000, 1'b1);
        runDirected(15'h4000, 1'b0, 4'd6, 0,  15'h4000, 1'b0);
        runDirected(15'h7F00, 1'b1, 4'd7, 7,  15'h0000, 1'b0);
        runDirected(15'h7FFF, 1'b1, 4'd8, 15, 15'h0000, 1'b1);
        runDirected(15'h3FFF, 1'b1, 4'd9, 0,  15'h3FFF, 1'b0);

        // Backpressure: only two operands fit while rdy_i is low
        $display("[TB] backpressure");
        bp_ops[0] = 15'h0001;
        bp_ops[1] = 15'h0123;
        bp_ops[2] = 15'h7000;
        bp_ops[3] = 15'h0F0F;
        rdy_i  = 1'b0;
        idx    = 0;
        vld_i  = 1'b1;
        in_op  = bp_ops[0];
        mode_i = 1'b0;
        tag_i  = 4'd10;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            f = rdy_o;
            @(posedge clk);
            #1;
            if (f && idx < 4) begin
                idx++;
                if (idx < 4) begin
                    in_op = bp_ops[idx];
                    tag_i = TAG_W'(10 + idx);
                end else begin
                    vld_i = 1'b0;
                end
            end
        end
        checkOutput("bp_accepted", idx, 2);
        @(negedge clk);
        checkOutput("bp_rdy_o", rdy_o, 0);
        checkOutput("bp_vld_o", vld_o, 1);
        s_cnt  = cnt_o;
        s_norm = norm_o;
        s_tag  = tag_o;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("bp_stable_cnt", cnt_o, s_cnt);
            checkOutput("bp_stable_norm", norm_o, s_norm);
            checkOutput("bp_stable_tag", tag_o, s_tag);
        end
        @(posedge clk);
        #1;
        rdy_i = 1'b1;
        base  = out_count;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("b2b_vld", vld_o, 1);
            f = rdy_o && vld_i;
            @(posedge clk);
            #1;
            if (f && idx < 4) begin
                idx++;
                if (idx < 4) begin
                    in_op = bp_ops[idx];
                    tag_i = TAG_W'(10 + idx);
                end else begin
                    vld_i = 1'b0;
                end
            end
        end
        checkOutput("bp_all_accepted", idx, 4);
        checkOutput("b2b_count", out_count - base, 4);

        // Random stream of 1000 operands with random valid/ready
        $display("[TB] random stream");
        target = acc_count + 1000;
        cycles = 0;
        while (acc_count < target && cycles < 20000) begin
            if (!vld_i && $urandom_range(0, 3) != 0) begin
                rop    = IN_W'($urandom) >> $urandom_range(0, 15);
                mode_i = 1'($urandom_range(0, 1));
                in_op  = mode_i ? ~rop : rop;
                tag_i  = TAG_W'($urandom);
                vld_i  = 1'b1;
            end
            rdy_i = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            f = vld_i && rdy_o;
            @(posedge clk);
            #1;
            cycles++;
            if (f) vld_i = 1'b0;
        end
        vld_i = 1'b0;
        checkOutput("rand_accept_done", acc_count >= target, 1);
        rdy_i  = 1'b1;
        cycles = 0;
        while (exp_q.size() > 0 && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("rand_drain_empty", exp_q.size(), 0);
        checkOutput("rand_in_out_balance", out_count, acc_count);

        // Reset with two operands in flight
        $display("[TB] reset mid-operation");
        rdy_i = 1'b0;
        applyStimulus(15'h0010, 1'b0, 4'd1);
        applyStimulus(15'h0020, 1'b0, 4'd2);
        @(negedge clk);
        checkOutput("rst_mid_full_vld", vld_o, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_vld_o", vld_o, 0);
        exp_q.delete();
        base = out_count;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_i = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_rdy_o", rdy_o, 1);
        checkOutput("rst_mid_vld_after", vld_o, 0);
        for (int c = 0; c < 10; c++) @(posedge clk);
        #1;
        checkOutput("rst_mid_no_stale", out_count - base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
